// File: rtl/stbus_rx_deser.sv
// ST-BUS receive deserializer: extracts one 8-bit channel per frame from the
// serial stream and buffers it in a 4-entry first-word-fall-through FIFO.
module stbus_rx_deser #(
    parameter int unsigned CH_SEL = 0
) (
    input  logic       clk50,
    input  logic       reset_in_rg,
    input  logic       c4,
    input  logic       f0,
    input  logic       data_from_dt,
    input  logic       select,
    input  logic       rd_en,
    input  logic       clr_ovf,
    output logic [7:0] rd_data,
    output logic       cpu_int,
    output logic [2:0] fifo_cnt,
    output logic       overflow,
    output logic       locked
);

    localparam logic [4:0] CH = 5'(CH_SEL);

    logic       c4_s1, c4_s2, c4_s3;
    logic       f0_s1, f0_s2;
    logic       d_s1, d_s2;
    logic       c4_rise;

    logic       phase;
    logic [7:0] bitcnt;
    logic [7:0] shreg;
    logic [7:0] byte_val;
    logic       byte_done;

    logic [7:0] mem [4];
    logic [1:0] wr_ptr, rd_ptr;

    logic       pop, push, push_ok, drop;
    logic [1:0] nxt_rd_ptr;
    logic [2:0] nxt_cnt;
    logic [7:0] head_nxt;

    assign c4_rise = c4_s2 & ~c4_s3;

    assign pop        = rd_en && (fifo_cnt != 3'd0);
    assign push       = byte_done && select;
    assign push_ok    = push && ((fifo_cnt != 3'd4) || pop);
    assign drop       = push && (fifo_cnt == 3'd4) && !pop;
    assign nxt_rd_ptr = rd_ptr + (pop ? 2'd1 : 2'd0);

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        nxt_cnt = fifo_cnt;
        case ({push_ok, pop})
            2'b10:   nxt_cnt = fifo_cnt + 3'd1;
            2'b01:   nxt_cnt = fifo_cnt - 3'd1;
            default: nxt_cnt = fifo_cnt;
        endcase
        // A byte written this cycle into the slot that becomes the head bypasses the array.
        head_nxt = mem[nxt_rd_ptr];
        if (push_ok && (wr_ptr == nxt_rd_ptr))
            head_nxt = byte_val;
    end

    // NOTE: non-blocking assignments so every flop samples the values from before the edge.
    always_ff @(posedge clk50) begin
        if (reset_in_rg) begin
            c4_s1     <= 1'b0;
            c4_s2     <= 1'b0;
            c4_s3     <= 1'b0;
            f0_s1     <= 1'b0;
            f0_s2     <= 1'b0;
            d_s1      <= 1'b0;
            d_s2      <= 1'b0;
            phase     <= 1'b0;
            bitcnt    <= 8'd0;
            shreg     <= 8'd0;
            byte_val  <= 8'd0;
            byte_done <= 1'b0;
            locked    <= 1'b0;
        end else begin
            c4_s1     <= c4;
            c4_s2     <= c4_s1;
            c4_s3     <= c4_s2;
            f0_s1     <= f0;
            f0_s2     <= f0_s1;
            d_s1      <= data_from_dt;
            d_s2      <= d_s1;
            byte_done <= 1'b0;
            if (c4_rise) begin
                if (!f0_s2) begin
                    phase  <= 1'b0;
                    bitcnt <= 8'd0;
                    shreg  <= 8'd0;
                    locked <= 1'b1;
                end else if (locked) begin
                    phase <= ~phase;
                    if (phase) begin
                        shreg  <= {shreg[6:0], d_s2};
                        bitcnt <= bitcnt + 8'd1;
                        if ((bitcnt[7:3] == CH) && (bitcnt[2:0] == 3'd7)) begin
                            byte_val  <= {shreg[6:0], d_s2};
                            byte_done <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    // NOTE: the storage array is not reset; pointers and count define which entries are valid.
    always_ff @(posedge clk50) begin
        if (!reset_in_rg && push_ok)
            mem[wr_ptr] <= byte_val;
    end

    always_ff @(posedge clk50) begin
        if (reset_in_rg) begin
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            fifo_cnt <= 3'd0;
            rd_data  <= 8'd0;
            cpu_int  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 2'd1;
            rd_ptr   <= nxt_rd_ptr;
            fifo_cnt <= nxt_cnt;
            if (nxt_cnt != 3'd0)
                rd_data <= head_nxt;
            cpu_int <= (fifo_cnt != 3'd0);
            if (drop)
                overflow <= 1'b1;
            else if (clr_ovf)
                overflow <= 1'b0;
        end
    end

endmodule

// File: doc/stbus_rx_deser.md
STBUS_RX_DESER -- requirements
Module: stbus_rx_deser

Interface
REQ-001 Parameter CH_SEL, default 0, meaning ST-BUS channel (0..31) captured into the FIFO.
REQ-002 clk50  input  1  sole system clock; all state updates on rising edge.
REQ-003 reset_in_rg  input  1  synchronous, active-high reset.
REQ-004 c4  input  1  ST-BUS 4.096 MHz bit clock, asynchronous to clk50.
REQ-005 f0  input  1  ST-BUS frame pulse, active low, asynchronous to clk50.
REQ-006 data_from_dt  input  1  ST-BUS serial receive data, MSB first.
REQ-007 select  input  1  capture enable; 0 SHALL block FIFO pushes only.
REQ-008 rd_en  input  1  consumer pop request, one byte per asserted cycle.
REQ-009 clr_ovf  input  1  clears the overflow flag.
REQ-010 rd_data  output  8  FIFO head byte (first-word-fall-through).
REQ-011 cpu_int  output  1  registered level: FIFO holds at least one byte.
REQ-012 fifo_cnt  output  3  current FIFO occupancy, 0..4.
REQ-013 overflow  output  1  sticky: a byte was dropped because the FIFO was full.
REQ-014 locked  output  1  a frame pulse has been seen since reset.

Function
REQ-015 c4, f0, data_from_dt SHALL each pass through a 2-flop synchronizer; a third c4 flop SHALL form c4_rise = c4_s2 AND NOT c4_s3 (single clk50 pulse).
REQ-016 All framing and sampling actions SHALL occur only in cycles where c4_rise=1.
REQ-017 On c4_rise with synchronized f0=0: phase<=0, bitcnt<=0, locked<=1; no bit sampled.
REQ-018 On c4_rise with f0=1: phase toggles; when phase was 1, data_s SHALL shift into an 8-bit shift register (LSB side) and bitcnt (8 bits) SHALL increment, wrapping 255->0.
REQ-019 No bit SHALL be sampled while locked=0.
REQ-020 A byte SHALL complete when a bit is sampled with bitcnt[7:3]=CH_SEL and bitcnt[2:0]=7; the completed byte SHALL include that bit.
REQ-021 A completed byte SHALL be pushed into the 4-entry FIFO in the following cycle when select=1; when select=0 it SHALL be discarded without setting overflow.
REQ-022 f0 arriving mid-frame SHALL realign bitcnt to 0 immediately; a partially assembled byte SHALL be discarded.
REQ-023 Push when fifo_cnt=4 and no pop in the same cycle: byte dropped, overflow<=1, FIFO contents unchanged.
REQ-024 Push and pop in the same cycle SHALL both take effect, including at full (count unchanged, no overflow) and at empty-with-pop (pop ignored, count becomes 1).
REQ-025 rd_en with fifo_cnt=0 SHALL be ignored; rd_data SHALL hold its last value.
REQ-026 rd_data SHALL present the oldest byte with zero-cycle read latency; the next byte SHALL appear in the cycle after a pop.
REQ-027 cpu_int SHALL equal (fifo_cnt != 0) registered, i.e. one clk50 cycle after fifo_cnt changes.
REQ-028 clr_ovf=1 SHALL clear overflow; if clr_ovf coincides with a new overflow event, overflow SHALL remain 1.
REQ-029 FIFO pointers SHALL be 2 bits and wrap modulo 4; fifo_cnt SHALL never exceed 4.

Reset
REQ-030 reset_in_rg=1 at a clk50 edge SHALL clear: synchronizers, phase, bitcnt, shift register, FIFO pointers, fifo_cnt=0, rd_data=0, cpu_int=0, overflow=0, locked=0.
REQ-031 Reset asserted mid-byte or mid-frame SHALL discard all partial and buffered data; capture resumes only after the next f0.
REQ-032 Reset SHALL take priority over every other input in the same cycle.

Verification
REQ-033 CH_SEL=0, select=1: f0 then channel 0 = 0xA5 -> one push, rd_data=0xA5, fifo_cnt=1, cpu_int=1 one cycle later.
REQ-034 CH_SEL=5: frame carrying channels 0..31 = index value -> only 0x05 pushed; frame wrap without new f0 -> second 0x05 pushed next frame.
REQ-035 Five frames, channel bytes 0x11..0x55, no reads -> fifo_cnt=4, overflow=1, reads yield 0x11,0x22,0x33,0x44; clr_ovf -> overflow=0.
REQ-036 FIFO full, push and rd_en same cycle -> fifo_cnt stays 4, overflow stays 0, order preserved.
REQ-037 Data before any f0 -> no pushes, locked=0; f0 mid-byte -> partial byte discarded, next aligned byte correct.
REQ-038 reset_in_rg pulse with fifo_cnt=3 -> fifo_cnt=0, cpu_int=0, locked=0 next cycle; no push until after next f0.
